// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: RST/FETCH/HOLD sequencing, pending-redirect capture and next-PC select.
// Optional perf counters enabled by defining FETCH_CTRL_PERF_EN; otherwise both counters read 0.
module fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [1:0]  redirect_sel,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic        pc_en,
    output logic [1:0]  jump_ctrl,
    output logic        ifid_we,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        pend_v;
    logic [1:0]  pend_sel;
    logic        redir_vld;

    // A select code of 00 means "no redirect" and is dropped entirely.
    assign redir_vld = redirect && (redirect_sel != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        pc_en     = 1'b0;
        case (state)
            ST_RST: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (stall) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    pc_en     = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

    // The delay slot is always written into IF/ID; redirects only steer the next PC.
    assign ifid_we = pc_en;

    always_comb begin
        jump_ctrl = 2'b00;
        if (pc_en) begin
            if (redir_vld) begin
                jump_ctrl = redirect_sel;
            end else if (pend_v) begin
                jump_ctrl = pend_sel;
            end
        end
    end

    // Any PC advance consumes the pending redirect; a frozen PC latches the newest one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v   <= 1'b0;
            pend_sel <= 2'b00;
        end else if (pc_en) begin
            pend_v   <= 1'b0;
        end else if (redir_vld) begin
            pend_v   <= 1'b1;
            pend_sel <= redirect_sel;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_q <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            if (pc_en) begin
                fetch_q <= fetch_q + 32'd1;
            end
            if (stall && (state != ST_RST)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_q;
    assign stall_cnt = stall_q;
`else
    assign fetch_cnt = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming fetch, stall/hold, pending redirects, mid-run reset.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [1:0]  redirect_sel;
    logic        imem_ready;
    logic        imem_req;
    logic        pc_en;
    logic [1:0]  jump_ctrl;
    logic        ifid_we;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_sel(redirect_sel),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .pc_en       (pc_en),
        .jump_ctrl   (jump_ctrl),
        .ifid_we     (ifid_we),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_io(input string tag, input logic e_req, input logic e_en, input logic [1:0] e_jc);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, e_en});
        chk({tag, ".ifid_we"}, {31'd0, ifid_we}, {31'd0, e_en});
        chk({tag, ".jump_ctrl"}, {30'd0, jump_ctrl}, {30'd0, e_jc});
    endtask

    task automatic drive(input logic s, input logic rdy, input logic rd, input logic [1:0] sel);
        stall        = s;
        imem_ready   = rdy;
        redirect     = rd;
        redirect_sel = sel;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        #2;
        chk_io("rst_async", 1'b0, 1'b0, 2'b00);
        chk("rst_async.pend_v", {31'd0, dut.pend_v}, 32'd0);
        chk("rst_async.fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_async.stall_cnt", stall_cnt, 32'd0);
        tick();
        tick();
        chk_io("rst_held", 1'b0, 1'b0, 2'b00);

        // Streaming fetch: first request in the second cycle after release
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        chk_io("stream.c1", 1'b0, 1'b0, 2'b00);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk_io("stream.en", 1'b1, 1'b1, 2'b00);
            tick();
        end
        chk("stream.fetch_cnt", fetch_cnt, PERF ? 32'd10 : 32'd0);
        chk("stream.stall_cnt", stall_cnt, 32'd0);

        // Stall for three cycles, then release out of HOLD
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        chk_io("stall.a", 1'b1, 1'b0, 2'b00);
        tick();
        chk_io("stall.b", 1'b0, 1'b0, 2'b00);
        tick();
        chk_io("stall.c", 1'b0, 1'b0, 2'b00);
        tick();
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        chk_io("stall.release", 1'b0, 1'b1, 2'b00);
        tick();
        chk_io("stall.refetch", 1'b1, 1'b1, 2'b00);
        chk("stall.stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
        chk("stall.fetch_cnt", fetch_cnt, PERF ? 32'd11 : 32'd0);

        // Redirect jr while memory is not ready: captured, then applied on completion
        drive(1'b0, 1'b0, 1'b1, 2'b11);
        chk_io("pend.w1", 1'b1, 1'b0, 2'b00);
        tick();
        chk("pend.set", {31'd0, dut.pend_v}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        chk_io("pend.w2", 1'b1, 1'b0, 2'b00);
        tick();
        tick();
        chk_io("pend.w4", 1'b1, 1'b0, 2'b00);
        tick();
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        chk_io("pend.apply", 1'b1, 1'b1, 2'b11);
        tick();
        chk("pend.clear", {31'd0, dut.pend_v}, 32'd0);
        chk_io("pend.after", 1'b1, 1'b1, 2'b00);

        // Newest redirect overwrites the pending one
        drive(1'b0, 1'b0, 1'b1, 2'b01);
        tick();
        chk("newest.sel01", {30'd0, dut.pend_sel}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 2'b10);
        tick();
        chk("newest.sel10", {30'd0, dut.pend_sel}, 32'd2);
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        chk_io("newest.apply", 1'b1, 1'b1, 2'b10);
        tick();
        chk_io("newest.after", 1'b1, 1'b1, 2'b00);

        // Redirect in an enabled cycle goes straight to the mux
        drive(1'b0, 1'b1, 1'b1, 2'b10);
        chk_io("direct", 1'b1, 1'b1, 2'b10);
        tick();
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        chk("direct.pend_v", {31'd0, dut.pend_v}, 32'd0);
        chk_io("direct.after", 1'b1, 1'b1, 2'b00);

        // Select code 00 is ignored
        drive(1'b0, 1'b0, 1'b1, 2'b00);
        tick();
        chk("sel00.pend_v", {31'd0, dut.pend_v}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        chk_io("sel00.next", 1'b1, 1'b1, 2'b00);
        tick();

        // Reset during HOLD with a pending redirect
        drive(1'b1, 1'b1, 1'b1, 2'b01);
        chk_io("midrst.enter", 1'b1, 1'b0, 2'b00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        chk("midrst.pend_v", {31'd0, dut.pend_v}, 32'd1);
        chk_io("midrst.hold", 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        #1;
        chk_io("midrst.async", 1'b0, 1'b0, 2'b00);
        chk("midrst.pend_clr", {31'd0, dut.pend_v}, 32'd0);
        chk("midrst.fetch_cnt", fetch_cnt, 32'd0);
        chk("midrst.stall_cnt", stall_cnt, 32'd0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        chk_io("restart.c1", 1'b0, 1'b0, 2'b00);
        tick();
        chk_io("restart.c2", 1'b1, 1'b1, 2'b00);
        tick();
        chk("restart.fetch_cnt", fetch_cnt, PERF ? 32'd1 : 32'd0);
        chk("restart.stall_cnt", stall_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
